// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: start, 8 data bits LSB first, optional even parity, stop; define UART_TX_PARITY_EN for 8E1, else 8N1.
// TX_OUT drops on the accept edge, frame is 10/11 bit times; tx_start is ignored while tx_busy is high.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] TX_DATA,
    input  logic       PARITY_BIT,
    output logic       load_data,
    output logic       TX_OUT,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] tx_state
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Plain vector so the illegal codes 5-7 stay representable and recoverable.
    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`else
    logic          unused_parity;
    assign unused_parity = PARITY_BIT;
`endif

    assign load_data = tx_start & (state == IDLE) & ~rst;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign tx_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            tx_done  <= 1'b0;
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (load_data) begin
                        shreg   <= TX_DATA;
`ifdef UART_TX_PARITY_EN
                        par_bit <= PARITY_BIT;
`endif
                        state   <= START;
                        TX_OUT  <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        TX_OUT  <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            TX_OUT <= par_bit;
`else
                            state  <= STOP;
                            TX_OUT <= 1'b1;
`endif
                        end else begin
                            TX_OUT <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    TX_OUT <= 1'b1;
                    if (bit_end) begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    TX_OUT   <= 1'b1;
                    tx_busy  <= 1'b0;
                    baud_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT = 4 and an XOR parity generator.
module tb_uart_tx_ctrl;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NBITS  = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NBITS  = 10;
`endif
    localparam int FCYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst, tx_start, parity_bit, load_data, tx_out, tx_busy, tx_done;
    logic [7:0] tx_data;
    logic [2:0] tx_state;
    int         checks = 0;
    int         errors = 0;

    logic line_s [0:FCYC];
    logic busy_s [0:FCYC];
    logic done_s [0:FCYC];
    logic ld_accept, ld_mid;
    logic el, eb, ed;

    always #5 clk = ~clk;

    // Parity generator: even parity of the byte, enabled by load_data.
    assign parity_bit = load_data & (^tx_data);

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .TX_DATA   (tx_data),
        .PARITY_BIT(parity_bit),
        .load_data (load_data),
        .TX_OUT    (tx_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_state  (tx_state)
    );

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && PAR_EN) return ^d;
        return 1'b1;
    endfunction

    // Called at a negedge with tx_start/tx_data already driven; records one frame.
    task automatic capture(input logic keep, input logic [7:0] next_d, input int pulse_at);
        #1;
        ld_accept = load_data;
        ld_mid    = 1'b0;
        @(posedge clk);
        #1;
        tx_start = keep;
        tx_data  = next_d;
        for (int k = 0; k <= FCYC; k++) begin
            @(negedge clk);
            line_s[k] = tx_out;
            busy_s[k] = tx_busy;
            done_s[k] = tx_done;
            if (k == pulse_at) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end
            if (pulse_at >= 0 && k == pulse_at + 1) begin
                tx_start = 1'b0;
                tx_data  = next_d;
            end
            #1;
            if (k < FCYC) ld_mid = ld_mid | load_data;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tx_start = 1'b1; tx_data = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({tx_out, tx_busy, tx_done, load_data} !== 4'b1000 || tx_state !== 3'd0) begin
                errors++;
                $display("FAIL reset_state: out/busy/done/load=%b%b%b%b state=%0d, required 1000 state=0",
                         tx_out, tx_busy, tx_done, load_data, tx_state);
            end
        end
        rst = 1'b0; tx_start = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release_idle: out=%b busy=%b state=%0d, required 1 0 0", tx_out, tx_busy, tx_state);
        end
    endtask

    task automatic test_parity;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'hA5;
        capture(1'b0, 8'hA5, -1);
        checks++;
        if (ld_accept !== 1'b1 || ld_mid !== 1'b0) begin
            errors++;
            $display("FAIL a5_load_data: accept=%b mid=%b, required 1 0", ld_accept, ld_mid);
        end
        for (int k = 0; k <= FCYC; k++) begin
            el = (k < FCYC) ? exp_bit(8'hA5, k / CPB) : 1'b1;
            eb = (k < FCYC); ed = (k == FCYC);
            checks++;
            if (line_s[k] !== el || busy_s[k] !== eb || done_s[k] !== ed) begin
                errors++;
                $display("FAIL a5_frame cycle %0d: line/busy/done=%b%b%b, required %b%b%b",
                         k, line_s[k], busy_s[k], done_s[k], el, eb, ed);
            end
        end
    endtask

    task automatic test_odd_data;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h07;
        capture(1'b0, 8'h07, -1);
        for (int k = 0; k <= FCYC; k++) begin
            el = (k < FCYC) ? exp_bit(8'h07, k / CPB) : 1'b1;
            eb = (k < FCYC); ed = (k == FCYC);
            checks++;
            if (line_s[k] !== el || busy_s[k] !== eb || done_s[k] !== ed) begin
                errors++;
                $display("FAIL 07_frame cycle %0d: line/busy/done=%b%b%b, required %b%b%b",
                         k, line_s[k], busy_s[k], done_s[k], el, eb, ed);
            end
        end
    endtask

    task automatic test_busy_request;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'hA5;
        capture(1'b0, 8'hA5, 4 * CPB + 1);
        checks++;
        if (ld_mid !== 1'b0) begin
            errors++;
            $display("FAIL busy_load_data: load_data mid-frame=%b, required 0", ld_mid);
        end
        for (int k = 0; k <= FCYC; k++) begin
            el = (k < FCYC) ? exp_bit(8'hA5, k / CPB) : 1'b1;
            eb = (k < FCYC); ed = (k == FCYC);
            checks++;
            if (line_s[k] !== el || busy_s[k] !== eb || done_s[k] !== ed) begin
                errors++;
                $display("FAIL busy_frame cycle %0d: line/busy/done=%b%b%b, required %b%b%b",
                         k, line_s[k], busy_s[k], done_s[k], el, eb, ed);
            end
        end
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_state !== 3'd0) begin
                errors++;
                $display("FAIL busy_no_second_frame cycle %0d: out=%b busy=%b state=%0d, required 1 0 0",
                         k, tx_out, tx_busy, tx_state);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h3C;
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'h3C : 8'hC3;
            capture((f == 0), 8'hC3, -1);
            checks++;
            if (ld_accept !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept frame %0d: load_data=%b, required 1", f, ld_accept);
            end
            for (int k = 0; k <= FCYC; k++) begin
                el = (k < FCYC) ? exp_bit(d, k / CPB) : 1'b1;
                eb = (k < FCYC); ed = (k == FCYC);
                checks++;
                if (line_s[k] !== el || busy_s[k] !== eb || done_s[k] !== ed) begin
                    errors++;
                    $display("FAIL b2b_frame%0d cycle %0d: line/busy/done=%b%b%b, required %b%b%b",
                             f, k, line_s[k], busy_s[k], done_s[k], el, eb, ed);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h55;
        @(posedge clk); #1 tx_start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (tx_state !== 3'd2 || tx_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: state=%0d out=%b, required 2 0", tx_state, tx_out);
        end
        #1 rst = 1'b1; tx_start = 1'b1;
        #1;
        checks++;
        if ({tx_out, tx_busy, tx_done, load_data} !== 4'b1000 || tx_state !== 3'd0) begin
            errors++;
            $display("FAIL midrst_async: out/busy/done/load=%b%b%b%b state=%0d, required 1000 state=0",
                     tx_out, tx_busy, tx_done, load_data, tx_state);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tx_done !== 1'b0 || tx_out !== 1'b1) begin
                errors++;
                $display("FAIL midrst_hold: done=%b out=%b, required 0 1", tx_done, tx_out);
            end
        end
        rst = 1'b0; tx_start = 1'b1; tx_data = 8'h81;
        capture(1'b0, 8'h81, -1);
        for (int k = 0; k <= FCYC; k++) begin
            el = (k < FCYC) ? exp_bit(8'h81, k / CPB) : 1'b1;
            eb = (k < FCYC); ed = (k == FCYC);
            checks++;
            if (line_s[k] !== el || busy_s[k] !== eb || done_s[k] !== ed) begin
                errors++;
                $display("FAIL 81_frame cycle %0d: line/busy/done=%b%b%b, required %b%b%b",
                         k, line_s[k], busy_s[k], done_s[k], el, eb, ed);
            end
        end
    endtask

    task automatic test_illegal_state;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h00;
        @(posedge clk); #1 tx_start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (tx_out !== 1'b0 || tx_state !== 3'd2) begin
            errors++;
            $display("FAIL illegal_pre: out=%b state=%0d, required 0 2", tx_out, tx_state);
        end
        force dut.state = 3'd7;
        #1 release dut.state;
        #1;
        checks++;
        if (tx_state !== 3'd7) begin
            errors++;
            $display("FAIL illegal_forced: state=%0d, required 7", tx_state);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_state !== 3'd0 || tx_out !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_recover: state=%0d out=%b busy=%b, required 0 1 0", tx_state, tx_out, tx_busy);
        end
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            checks++;
            if (tx_state !== 3'd0 || tx_out !== 1'b1 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL illegal_settled cycle %0d: state=%0d out=%b done=%b, required 0 1 0",
                         k, tx_state, tx_out, tx_done);
            end
        end
    endtask

    initial begin
        rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        test_reset();
        test_parity();
        test_odd_data();
        test_busy_request();
        test_back_to_back();
        test_reset_mid_frame();
        test_illegal_state();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
